down_timer: RTL and testbench

- Loadable WIDTH-bit down counter/timer; the decrementing counterpart to the lab's half-adder up counter.
- Decrement datapath is a ripple chain of WIDTH half-subtractor cells. Bit 0 borrow-in = En; bit i borrow-in = borrow-out of bit i-1.
- A 3-state FSM sequences load, countdown, and terminal event.
- Used as a programmable delay/timeout source for lab FSMs.

---
 rtl/down_timer.sv | 101 ++++++++++
 tb/tb_down_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable WIDTH-bit down counter / timeout source.
// The decrement path is a ripple chain of half-subtractor cells whose
// borrow-in at bit 0 is En. A three-state FSM (IDLE, RUN, DONE) decides
// when the chain result is written back to the count register.
// Optional build macro: DOWN_TIMER_AUTORELOAD_EN. When it is defined, the
// terminal decrement reloads the last loaded value and the timer stays in
// RUN, giving a periodic Done pulse. The default build is one-shot.
// Handshake: none. Load is a single-cycle strobe sampled on the rising
// Clk edge and takes priority over En. En is a level-sensitive enable.
// Done is a registered pulse lasting exactly one cycle per terminal event.
module down_timer #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             En,
  output logic [WIDTH-1:0] Count,
  output logic             Borrow,
  output logic             Done,
  output logic             Busy,
  output logic [1:0]       DbgState_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             done_q;
  logic [WIDTH:0]   chain_b;
`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  // Ripple chain of half-subtractor cells: diff = a ^ b_in, b_out = ~a & b_in.
  always_comb begin
    count_d    = '0;
    chain_b    = '0;
    chain_b[0] = En;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i]     = count_q[i] ^ chain_b[i];
      chain_b[i + 1] = ~count_q[i] & chain_b[i];
    end
  end

  // FSM with registered count, reload value and Done pulse.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else if (Load) begin
      // Load wins over everything, including a terminal decrement.
      count_q  <= LoadVal;
      done_q   <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_q <= LoadVal;
`endif
      state_q  <= (LoadVal != '0) ? RUN : IDLE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          // Count is never 0 in RUN, so it is either 1 (terminal) or larger.
          if (En) begin
            if (count_q == WIDTH'(1)) begin
              done_q <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
              count_q <= reload_q;
`else
              count_q <= '0;
              state_q <= DONE;
`endif
            end else begin
              count_q <= count_d;
            end
          end
        end
        default: begin
          // IDLE and DONE hold the count; En only affects Borrow here.
        end
      endcase
    end
  end

  assign Count      = count_q;
  assign Borrow     = chain_b[WIDTH];
  assign Done       = done_q;
  assign Busy       = (state_q == RUN);
  assign DbgState_o = state_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed and randomized bench for down_timer against a
// behavioural timer model, for both the one-shot and the auto-reload build
// (DOWN_TIMER_AUTORELOAD_EN).
module tb_down_timer;

  localparam int WIDTH = 3;

  logic             Clk;
  logic             Rst;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic             En;
  logic [WIDTH-1:0] Count;
  logic             Borrow;
  logic             Done;
  logic             Busy;
  logic [1:0]       DbgState_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected counts, one entry pushed per modelled clock edge.
  logic [WIDTH-1:0] exp_q[$];

  // Behavioural model state: integer count, a running flag, a pulse flag.
  int m_cnt;
  int m_reload;
  bit m_running;
  bit m_done;

  down_timer #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Load       (Load),
    .LoadVal    (LoadVal),
    .En         (En),
    .Count      (Count),
    .Borrow     (Borrow),
    .Done       (Done),
    .Busy       (Busy),
    .DbgState_o (DbgState_o)
  );

  // Clock / reset block.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_reload  = 0;
    m_running = 0;
    m_done    = 0;
  endtask

  // One rising edge of the timer, described by its observable rules.
  task automatic model_edge(input bit ld, input int v, input bit e);
    m_done = 0;
    if (ld) begin
      m_cnt     = v;
      m_reload  = v;
      m_running = (v != 0);
    end else if (m_running && e) begin
      if (m_cnt == 1) begin
        m_done = 1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        m_cnt = m_reload;
`else
        m_cnt     = 0;
        m_running = 0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    exp_q.push_back(WIDTH'(m_cnt));
  endtask

  task automatic check_outputs(input string tag);
    logic [WIDTH-1:0] exp_cnt;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      exp_cnt = exp_q.pop_front();
      check({tag, "_count"}, 32'(Count), 32'(exp_cnt));
    end
    check({tag, "_done"},   32'(Done),   32'(m_done));
    check({tag, "_busy"},   32'(Busy),   32'(m_running));
    check({tag, "_borrow"}, 32'(Borrow), 32'(En && (m_cnt == 0)));
  endtask

  // Driver: apply inputs at the falling edge, check 1 time unit after rise.
  task automatic step(input bit ld, input int v, input bit e, input string tag);
    @(negedge Clk);
    Load    = ld;
    LoadVal = WIDTH'(v);
    En      = e;
    @(posedge Clk);
    model_edge(ld, v, e);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
  task automatic reset_mid(input bit e, input string tag);
    @(posedge Clk);
    #2;
    En  = e;
    Load = 1'b0;
    Rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_count"},  32'(Count),  32'd0);
    check({tag, "_done"},   32'(Done),   32'd0);
    check({tag, "_busy"},   32'(Busy),   32'd0);
    check({tag, "_borrow"}, 32'(Borrow), 32'(e));
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    Rst     = 1'b1;
    Load    = 1'b0;
    LoadVal = '0;
    En      = 1'b0;
    model_reset();
    #1;
    check("reset_count", 32'(Count), 32'd0);
    check("reset_done",  32'(Done),  32'd0);
    check("reset_busy",  32'(Busy),  32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Load 5 and count down continuously, then idle with En high.
    step(1, 5, 0, "t2_load");
    for (int i = 0; i < 7; i++) step(0, 0, 1, "t2_run");

    // Load 3 with enable pattern 1,0,0,1,1 then a couple of extra cycles.
    step(1, 3, 1, "t3_load");
    step(0, 0, 1, "t3_en1");
    step(0, 0, 0, "t3_en0");
    step(0, 0, 0, "t3_en0");
    step(0, 0, 1, "t3_en1");
    step(0, 0, 1, "t3_en1");
    step(0, 0, 0, "t3_tail");

    // Load 6, reload with 4 when the count reaches 2.
    step(1, 6, 0, "t4_load");
    for (int i = 0; i < 4; i++) step(0, 0, 1, "t4_run");
    step(1, 4, 1, "t4_reload");
    for (int i = 0; i < 5; i++) step(0, 0, 1, "t4_run2");

    // Load of zero stays idle; Borrow follows En.
    step(1, 0, 1, "t5_load0");
    step(0, 0, 1, "t5_idle");
    step(0, 0, 0, "t5_idle_en0");

    // Load 2, count continuously (periodic in the auto-reload build).
    step(1, 2, 1, "t6_load");
    for (int i = 0; i < 6; i++) step(0, 0, 1, "t6_run");

    // Load at the terminal count: Load wins, no Done pulse.
    step(1, 1, 0, "t7_load1");
    step(1, 7, 1, "t7_load_over_term");
    step(0, 0, 1, "t7_run");

    // Asynchronous reset in the middle of a countdown.
    step(1, 6, 1, "t1_load");
    step(0, 0, 1, "t1_run");
    reset_mid(1, "t1_rst_en1");
    step(0, 0, 1, "t1_after");
    step(1, 4, 0, "t1_load2");
    reset_mid(0, "t1_rst_en0");

    // Randomized stimulus.
    for (int i = 0; i < 400; i++) begin
      bit ld;
      bit e;
      int v;
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      v  = $urandom_range(0, (1 << WIDTH) - 1);
      step(ld, v, e, "rand");
      if ($urandom_range(0, 199) == 0) reset_mid(e, "rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
